snow64_pipelined_count_leading_zeros: RTL
=========================================

Name: snow64_pipelined_count_leading_zeros

Overview:
- Parametrised, pipelined leading-zero counter for the snow64 datapath. Used for normalisation in the FPU and by the CLZ instruction.
- Generalises the fixed 16/32-bit combinational counters to any power-of-two width.
- Each binary-search halving step is one register stage.
- Valid/ready handshake with per-stage backpressure, bubble collapsing and a passthrough tag.

Parameters:
- WIDTH, 64, input width in bits; power of two, 4..128.
- TAG_WIDTH, 4, width of the opaque sideband tag carried with each operand; must be >= 1.
- Derived, not overridable: STAGES = $clog2(WIDTH); OUT_WIDTH = STAGES+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  WIDTH  operand.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_count  out  OUT_WIDTH  number of leading zeros, 0..WIDTH.
- out_zero  out  1  operand was all zeros.
- out_tag  out  TAG_WIDTH  tag of the operand that produced the result.

Behaviour:
- Reset (async assert): every stage valid bit = 0. out_valid=0, out_count=0, out_zero=0, out_tag=0. in_ready=1 while rst is low and the pipe is empty. Deasserting rst takes effect synchronously at the next clock edge.
- Reset mid-operation: all in-flight operands are discarded, no result is emitted, and the pipeline is empty on the first cycle after reset.
- Handshake: a transfer occurs on a clock edge where valid && ready. in_data and in_tag are sampled only on an input transfer. out_* hold stable while out_valid && !out_ready.
- Pipeline: stages S1..S_STAGES. Stage k (k = 1..STAGES) has h = WIDTH >> k.
  - If the upper h bits of the remaining window are nonzero: keep the upper h bits and set count bit (STAGES-k) = 0.
  - Otherwise: keep the lower h bits and set count bit (STAGES-k) = 1.
  - The last stage instead sets count bit 0 = !window[1].
- Zero input: zero flag is computed at input acceptance and carried through every stage. At output, if zero, out_count = WIDTH (MSB=1, all others 0) and out_zero=1. Otherwise the MSB is 0.
- Per-stage ready: ready_k = !valid_k || ready_(k+1), with ready_(STAGES+1) = out_ready. in_ready = ready_1. Bubbles collapse: an empty stage accepts even when downstream stalls.
- Latency: STAGES cycles from input transfer to out_valid when out_ready is held high (WIDTH=64: 6 cycles).
- Throughput: 1 result/cycle.
- Ordering: strictly in order, no reordering, no drops.
- Full pipeline with out_ready=0 → in_ready=0. On the same edge out_ready rises, the whole pipe shifts and a new input is accepted (simultaneous in/out transfer allowed).
- out_valid is driven from the S_STAGES valid bit. out_count, out_zero and out_tag are registered outputs with no combinational path from in_*. in_ready depends combinationally on out_ready.

Optional Feature:
- Macro SNOW64_PIPELINED_CLZ_CTZ_MODE_EN.
- When defined:
  - Adds input port in_ctz (1 bit, sampled with in_data).
  - If in_ctz=1, the operand is bit-reversed before S1, so out_count is the trailing-zero count.
  - Zero input still gives WIDTH and out_zero=1.
  - The mode bit travels with the operand, so mixed CLZ/CTZ streams are legal back to back.
- When undefined: the port is absent and the behaviour is CLZ only.

Test Plan:
- WIDTH=64, out_ready=1. Feed 64'h0000_0001_0000_0000 tag 3 → 6 cycles later out_count=31, out_zero=0, out_tag=3.
- WIDTH=64, feed 64'h0 → out_count=64, out_zero=1. Feed 64'h8000_0000_0000_0000 → out_count=0.
- WIDTH=16, 16 back-to-back operands 16'h8000>>i, i=0..15, tags i → counts 0..15 in order, one per cycle, in_ready stays 1.
- WIDTH=32, out_ready=0 for 10 cycles while in_valid=1 → exactly 5 accepted, then in_ready=0. Outputs hold stable. Raise out_ready → 5 results in order, and a new operand is accepted on the same edge.
- Assert rst asynchronously with 3 operands in flight → out_valid=0 immediately, no stale results after release, first new operand returns with normal latency.
- With SNOW64_PIPELINED_CLZ_CTZ_MODE_EN, WIDTH=64: 64'h0000_0000_0000_0100 with in_ctz=1 → 8. Same value with in_ctz=0 → 55. Alternate the two back to back → 8, 55, 8, 55.

Source files
------------

// File: rtl/snow64_pipelined_count_leading_zeros.sv
// rtl/snow64_pipelined_count_leading_zeros.sv - pipelined leading-zero counter, one binary-search halving per stage
// Optional trailing-zero mode: define SNOW64_PIPELINED_CLZ_CTZ_MODE_EN to add the in_ctz port.
module snow64_pipelined_count_leading_zeros #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 4,
  localparam int STAGES    = $clog2(WIDTH),
  localparam int OUT_WIDTH = STAGES + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
`ifdef SNOW64_PIPELINED_CLZ_CTZ_MODE_EN
  input  logic                 in_ctz,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_count,
  output logic                 out_zero,
  output logic [TAG_WIDTH-1:0] out_tag
);

  // Window bus: the window entering a stage of width w lives at bits [2w-1:w].
  // The full-width operand sits at the top; bits [1:0] would never exist.
  logic [2*WIDTH-1:2]   win_bus;
  logic [WIDTH-1:0]     operand;
  logic                 vld [0:STAGES];
  logic                 rdy [1:STAGES+1];
  logic [OUT_WIDTH-1:0] cnt [0:STAGES];
  logic                 zro [0:STAGES];
  logic [TAG_WIDTH-1:0] tag [0:STAGES];

`ifdef SNOW64_PIPELINED_CLZ_CTZ_MODE_EN
  // Bit-reverse the operand for trailing-zero mode so the same search applies
  always_comb begin
    operand = in_data;
    if (in_ctz) begin
      for (int i = 0; i < WIDTH; i++) begin
        operand[i] = in_data[WIDTH-1-i];
      end
    end
  end
`else
  assign operand = in_data;
`endif

  assign win_bus[2*WIDTH-1:WIDTH] = operand;
  assign vld[0]         = in_valid;
  assign cnt[0]         = '0;
  assign zro[0]         = ~|in_data;
  assign tag[0]         = in_tag;
  assign rdy[STAGES+1]  = out_ready;
  assign in_ready       = rdy[1];

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int H = WIDTH >> k;

    logic [2*H-1:0]       win_in;
    logic                 load;
    logic                 valid_q, valid_d;
    logic                 zero_q, zero_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [OUT_WIDTH-1:0] cnt_q, cnt_d;

    assign win_in = win_bus[4*H-1:2*H];
    // An empty stage always accepts, so bubbles collapse under a downstream stall
    assign rdy[k] = !valid_q || rdy[k+1];
    assign load   = rdy[k] && vld[k-1];

    // Stage occupancy and sideband carried alongside the operand
    always_comb begin
      valid_d = rdy[k] ? vld[k-1] : valid_q;
      zero_d  = zero_q;
      tag_d   = tag_q;
      if (load) begin
        zero_d = zro[k-1];
        tag_d  = tag[k-1];
      end
    end

    // Stage state register; reset drops every in-flight operand
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        zero_q  <= 1'b0;
        tag_q   <= '0;
        cnt_q   <= '0;
      end else begin
        valid_q <= valid_d;
        zero_q  <= zero_d;
        tag_q   <= tag_d;
        cnt_q   <= cnt_d;
      end
    end

    if (k < STAGES) begin : g_mid
      logic [H-1:0] win_q, win_d;

      // Halve the window: keep the upper half if it holds a one, else the lower
      always_comb begin
        win_d = win_q;
        cnt_d = cnt_q;
        if (load) begin
          if (|win_in[2*H-1:H]) begin
            win_d = win_in[2*H-1:H];
            cnt_d = cnt[k-1];
          end else begin
            win_d = win_in[H-1:0];
            cnt_d = cnt[k-1] | (OUT_WIDTH'(1) << (STAGES - k));
          end
        end
      end

      // Surviving half of the window
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          win_q <= '0;
        end else begin
          win_q <= win_d;
        end
      end

      assign win_bus[2*H-1:H] = win_q;
    end else begin : g_last
      logic unused_lsb;

      // The low bit of the final 2-bit window cannot change the count
      assign unused_lsb = win_in[0];

      // Final bit, and fold the zero flag into the count (WIDTH = MSB only)
      always_comb begin
        cnt_d = cnt_q;
        if (load) begin
          cnt_d = zro[k-1] ? OUT_WIDTH'(WIDTH)
                           : (cnt[k-1] | OUT_WIDTH'(!win_in[1]));
        end
      end
    end

    assign vld[k] = valid_q;
    assign cnt[k] = cnt_q;
    assign zro[k] = zero_q;
    assign tag[k] = tag_q;
  end

  assign out_valid = vld[STAGES];
  assign out_count = cnt[STAGES];
  assign out_zero  = zro[STAGES];
  assign out_tag   = tag[STAGES];

endmodule
